// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the program counter, drives
//                the instruction-memory word address and captures the
//                returned instruction into the IF/ID pipeline register,
//                with a valid/ready handshake toward decode. Redirects from
//                execute reload the PC and flush the IF/ID register.
//
//  Ports       : clk            - single clock, rising-edge
//                rst_n          - asynchronous active-low reset
//                pc_o           - fetch PC (registered), to IMEM address
//                inst_i         - IMEM read data, combinational from pc_o
//                redirect_i     - taken branch/jump from execute
//                redirect_pc_i  - redirect target
//                id_ready_i     - decode accepts IF/ID contents this cycle
//                id_valid_o     - IF/ID holds a live instruction
//                id_inst_o      - fetched instruction
//                id_pc_o        - PC of id_inst_o
//                id_pc4_o       - id_pc_o + 4 (link value)
//                misalign_o     - misaligned-redirect trap flag
//                                 (only with FETCH_MISALIGN_TRAP_EN)
//
//  Options     : FETCH_MISALIGN_TRAP_EN - when defined, a redirect to a
//                non-word-aligned target enters a TRAP state that halts
//                fetch until an aligned redirect arrives. When undefined,
//                the target's low two bits are simply ignored.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                           PC_WIDTH_LENGTH   = 32,
    parameter int                           INST_WIDTH_LENGTH = 32,
    parameter logic [PC_WIDTH_LENGTH-1:0]   RESET_PC          = 32'h0000_0000,
    parameter logic [INST_WIDTH_LENGTH-1:0] NOP_INST          = 32'h0000_0013
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic [PC_WIDTH_LENGTH-1:0]   pc_o,
    input  logic [INST_WIDTH_LENGTH-1:0] inst_i,
    input  logic                         redirect_i,
    input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc_i,
    input  logic                         id_ready_i,
    output logic                         id_valid_o,
    output logic [INST_WIDTH_LENGTH-1:0] id_inst_o,
    output logic [PC_WIDTH_LENGTH-1:0]   id_pc_o,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic                         misalign_o,
`endif
    output logic [PC_WIDTH_LENGTH-1:0]   id_pc4_o
);

    localparam logic [PC_WIDTH_LENGTH-1:0] c_pc_step = PC_WIDTH_LENGTH'(4);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        ST_TRAP = 2'd2
`endif
    } state_t;

    state_t                         state_q, state_d;
    logic [PC_WIDTH_LENGTH-1:0]     pc_q, pc_d;
    logic                           id_valid_q, id_valid_d;
    logic [INST_WIDTH_LENGTH-1:0]   id_inst_q, id_inst_d;
    logic [PC_WIDTH_LENGTH-1:0]     id_pc_q, id_pc_d;
    logic [PC_WIDTH_LENGTH-1:0]     id_pc4_q, id_pc4_d;

    logic [PC_WIDTH_LENGTH-1:0]     w_pc_plus4;
    logic [PC_WIDTH_LENGTH-1:0]     w_redirect_target;
    logic                           w_fire;

    // Addition wraps naturally modulo 2^PC_WIDTH_LENGTH.
    assign w_pc_plus4 = pc_q + c_pc_step;

    // The PC is always kept word-aligned, so the target's low bits are
    // dropped regardless of whether the trap is built in.
    assign w_redirect_target = {redirect_pc_i[PC_WIDTH_LENGTH-1:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = |redirect_pc_i[1:0];
`else
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^redirect_pc_i[1:0];
`endif

    // A fetch happens only when running, not being redirected, and the
    // IF/ID slot is either empty or being consumed this cycle.
    assign w_fire = (state_q == ST_RUN) && !redirect_i &&
                    (!id_valid_q || id_ready_i);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                if (redirect_i && w_misaligned) begin
                    state_d = ST_TRAP;
                end
`else
                state_d = ST_RUN;
`endif
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_TRAP: begin
                if (redirect_i && !w_misaligned) begin
                    state_d = ST_RUN;
                end
            end
`endif
            default: state_d = ST_BOOT;
        endcase

        if (redirect_i) begin
            // Payload registers keep stale contents; only valid is cleared.
            pc_d       = w_redirect_target;
            id_valid_d = 1'b0;
        end else if (w_fire) begin
            pc_d       = w_pc_plus4;
            id_valid_d = 1'b1;
            id_inst_d  = inst_i;
            id_pc_d    = pc_q;
            id_pc4_d   = w_pc_plus4;
        end else if (id_valid_q && id_ready_i) begin
            // Consumed while fetch is blocked (BOOT/TRAP): slot empties.
            id_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_inst_q  <= NOP_INST;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
        end
    end

    assign pc_o       = pc_q;
    assign id_valid_o = id_valid_q;
    assign id_inst_o  = id_inst_q;
    assign id_pc_o    = id_pc_q;
    assign id_pc4_o   = id_pc4_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_o = (state_q == ST_TRAP);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. An IMEM model returns a
//                PC-derived word; expected IF/ID contents are queued when a
//                fetch is expected and compared while they are presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] inst_i;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        id_ready_i = 1'b0;
    logic        id_valid_o;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc4_o;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_o          (pc_o),
        .inst_i        (inst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_ready_i    (id_ready_i),
        .id_valid_o    (id_valid_o),
        .id_inst_o     (id_inst_o),
        .id_pc_o       (id_pc_o),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_o    (misalign_o),
`endif
        .id_pc4_o      (id_pc4_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign inst_i = imem(pc_o);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_pc;
    logic        m_valid;
    int          m_state;   // 0 boot, 1 run, 2 trap

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_state = 0;
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt);
        logic fire;
        ent_t e;
        id_ready_i    = rdy;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        fire = (m_state == 1) && !redir && (!m_valid || rdy);
        @(posedge clk);
        #1;
        if (redir) begin
            sb.delete();
            m_valid = 1'b0;
            m_pc    = {tgt[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
            if (m_state == 1 && tgt[1:0] != 2'b00)      m_state = 2;
            else if (m_state == 2 && tgt[1:0] == 2'b00) m_state = 1;
            else if (m_state == 0)                      m_state = 1;
`else
            if (m_state == 0) m_state = 1;
`endif
        end else begin
            if (m_valid && rdy) begin
                void'(sb.pop_front());
                m_valid = 1'b0;
            end
            if (fire) begin
                e.pc   = m_pc;
                e.inst = imem(m_pc);
                sb.push_back(e);
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
            if (m_state == 0) m_state = 1;
        end
        chk("pc_o", pc_o, m_pc);
        chk("id_valid", {31'b0, id_valid_o}, {31'b0, m_valid});
        if (m_valid && sb.size() > 0) begin
            chk("id_inst", id_inst_o, sb[0].inst);
            chk("id_pc", id_pc_o, sb[0].pc);
            chk("id_pc4", id_pc4_o, sb[0].pc + 32'd4);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign", {31'b0, misalign_o}, {31'b0, (m_state == 2)});
`endif
    endtask

    initial begin
        model_reset();
        // Reset values while held in reset.
        #12;
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_valid", {31'b0, id_valid_o}, 32'h0);
        chk("rst_inst", id_inst_o, 32'h0000_0013);
        chk("rst_id_pc", id_pc_o, 32'h0);
        chk("rst_pc4", id_pc4_o, 32'h0);
        rst_n = 1'b1;

        // BOOT cycle then A, B.
        step(1'b1, 1'b0, 32'h0);
        chk("boot_valid", {31'b0, id_valid_o}, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("A_inst", id_inst_o, imem(32'h0));
        chk("A_pc4", id_pc4_o, 32'h4);
        step(1'b1, 1'b0, 32'h0);

        // Stall with B valid.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("stall_inst", id_inst_o, imem(32'h4));
            chk("stall_pc", pc_o, 32'h8);
        end
        step(1'b1, 1'b0, 32'h0);
        chk("C_inst", id_inst_o, imem(32'h8));
        step(1'b1, 1'b0, 32'h0);
        chk("D_pc4", id_pc4_o, 32'h10);

        // Redirect while decode is stalled.
        step(1'b0, 1'b1, 32'h100);
        chk("redir_valid", {31'b0, id_valid_o}, 32'h0);
        chk("redir_pc", pc_o, 32'h100);
        step(1'b1, 1'b0, 32'h0);
        chk("redir_id_pc", id_pc_o, 32'h100);
        step(1'b1, 1'b0, 32'h0);

        // PC wrap.
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0);
        chk("wrap_pc", pc_o, 32'h0);
        chk("wrap_pc4", id_pc4_o, 32'h0);
        step(1'b1, 1'b0, 32'h0);

        // Asynchronous reset between edges.
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_inst", id_inst_o, 32'h0000_0013);
        chk("arst_valid", {31'b0, id_valid_o}, 32'h0);
        chk("arst_pc", pc_o, 32'h0);
        chk("arst_id_pc", id_pc_o, 32'h0);
        model_reset();
        #2;
        rst_n = 1'b1;

        // Redirect during BOOT still enters RUN.
        step(1'b1, 1'b1, 32'h40);
        chk("boot_redir_pc", pc_o, 32'h40);
        step(1'b1, 1'b0, 32'h0);
        chk("boot_redir_id_pc", id_pc_o, 32'h40);

        // Misaligned redirect.
        step(1'b1, 1'b1, 32'h102);
        chk("mis_pc", pc_o, 32'h100);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h200);
        step(1'b1, 1'b0, 32'h0);
        chk("after_200_id_pc", id_pc_o, 32'h200);

        // Random ready pattern.
        for (int i = 0; i < 12; i++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 32'h0);
        end
        step(1'b1, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the instruction memory. Owns the program counter, drives the IMEM word address, and captures the returned instruction into the IF/ID pipeline register. Provides a valid/ready handshake to decode. Accepts branch/jump redirects from execute, which flush the IF/ID register.

## Interface
- `PC_WIDTH_LENGTH`, 32, PC and address width.
- `INST_WIDTH_LENGTH`, 32, instruction width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- `NOP_INST`, 32'h0000_0013, IF/ID instruction value after reset (`addi x0,x0,0`).

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst_n`  in  1  — reset is asynchronous and active-low.
- `pc_o`  out  PC_WIDTH_LENGTH  — current fetch PC; connects to IMEM `PC`.
- `inst_i`  in  INST_WIDTH_LENGTH  — IMEM read data; combinational from `pc_o` in the same cycle.
- `redirect_i`  in  1  — taken branch/jump from execute.
- `redirect_pc_i`  in  PC_WIDTH_LENGTH  — redirect target.
- `id_ready_i`  in  1  — decode accepts the IF/ID contents this cycle.
- `id_valid_o`  out  1  — IF/ID register holds a live instruction.
- `id_inst_o`  out  INST_WIDTH_LENGTH  — fetched instruction.
- `id_pc_o`  out  PC_WIDTH_LENGTH  — PC of `id_inst_o`.
- `id_pc4_o`  out  PC_WIDTH_LENGTH  — `id_pc_o + 4`, used for the JAL/JALR link value.
- `misalign_o`  out  1  — misaligned-redirect trap flag. Present only with `FETCH_MISALIGN_TRAP_EN`.

## Operation
- FSM states: BOOT, RUN, TRAP.
  - BOOT → RUN unconditionally after one cycle.
  - RUN → TRAP only on a misaligned redirect (macro on).
  - TRAP → RUN on an aligned redirect.
- Fetch fires when the state is RUN, `redirect_i`=0, and (`id_valid_o`=0 or `id_ready_i`=1).
- On fire:
  - `id_inst_o`←`inst_i`, `id_pc_o`←`pc`, `id_pc4_o`←`pc+4`, `id_valid_o`←1.
  - `pc`←`pc+4`.
- Drain without fetch (state ≠ RUN, `id_ready_i`=1, `id_valid_o`=1): `id_valid_o`←0.
- Stall (`id_valid_o`=1, `id_ready_i`=0, no redirect): PC and all IF/ID registers hold.
- Redirect (highest priority, in any state):
  - `pc`←`redirect_pc_i`, `id_valid_o`←0.
  - IF/ID payload registers hold their old values; their contents are don't-care while `id_valid_o`=0.
  - The instruction fetched in the redirect cycle is discarded.
- Redirect in BOOT: PC is loaded and the FSM still enters RUN next cycle.
- Arithmetic: `pc+4` wraps modulo 2^PC_WIDTH_LENGTH, so 32'hFFFF_FFFC → 32'h0000_0000. No carry out, no flag.
- `pc_o` is always word-aligned, so IMEM never returns high-Z to this block.
- Reset (asynchronous, also mid-operation):
  - `pc`=`RESET_PC`, state=BOOT, `id_valid_o`=0.
  - `id_inst_o`=`NOP_INST`, `id_pc_o`=0, `id_pc4_o`=0, `misalign_o`=0.
  - Any in-flight instruction is lost.

## Timing
- `pc_o` comes directly from a register; there is no combinational path from any input to `pc_o`.
- IMEM read is zero-latency: `inst_i` is sampled at the same edge that advances `pc`.
- Fetch-to-decode latency: 1 cycle. Instruction at PC P appears on `id_*` the cycle after `pc_o`=P.
- Redirect sampled at edge N:
  - `pc_o`=target during cycle N+1.
  - Target instruction has `id_valid_o`=1 after edge N+1.
  - Penalty: 1 bubble cycle.
- First valid instruction after `rst_n` release: `id_valid_o`=1 after the 2nd rising edge (BOOT cycle, then fire).
- Throughput: 1 instruction/cycle while `id_ready_i`=1.
- `id_ready_i` is combinational into the fire logic only; it never feeds `pc_o`.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc_i[1:0]`≠0 loads `pc` with the target bits [1:0] cleared and enters TRAP.
  - `misalign_o`=1 from the next cycle until the next aligned redirect or reset.
  - No fetches occur in TRAP.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - `redirect_pc_i[1:0]` is forced to 00, and fetch continues normally.
  - The `misalign_o` port and the TRAP state are removed.

## Test plan
- Reset with `RESET_PC`=0, IMEM words 0..3 = A,B,C,D, `id_ready_i`=1 → `id_inst_o` = A,B,C,D on consecutive cycles starting at the 2nd edge; `id_pc4_o` = 4,8,12,16.
- Stall: hold `id_ready_i`=0 for 3 cycles while B is valid → `id_inst_o`=B and `pc_o`=8 stay stable. On release, C follows in the next cycle with no duplicate and no skipped instruction.
- Redirect to 0x100 while `id_ready_i`=0 → `id_valid_o`=0 next cycle, `pc_o`=0x100, then the instruction at 0x100 is valid with `id_pc_o`=0x100.
- Wrap: redirect to 0xFFFF_FFFC → after that fetch, `pc_o`=0 and `id_pc4_o`=0.
- Assert `rst_n`=0 mid-stream, asynchronously between edges → all outputs take their reset values immediately: `id_inst_o`=0x13, `id_valid_o`=0.
- Macro on, redirect to 0x102 → `misalign_o`=1, `id_valid_o` stays 0, `pc_o`=0x100. A later redirect to 0x200 clears `misalign_o` and resumes fetch.
